// File: rtl/imem_loader_if.sv
// Boot-loader bus between the byte source / supervisor and imem_loader.
// Groups the byte-stream handshake, the instruction-memory write port and
// the load status outputs.
//   i_start, i_byte_valid, i_byte : load request and byte stream into the loader
//   o_byte_ready                  : loader accepts a byte this cycle
//   o_wr_en/o_wr_addr/o_wr_data   : one-cycle word write into instruction memory
//   o_busy/o_done/o_err/o_cpu_rst : load status and CPU reset request
//   o_checksum                    : XOR of all words written by the current/last load
// The slave modport is the loader itself; the master modport is its environment.
interface imem_loader_if #(
   parameter int unsigned MEM_SIZE = 1024
);
   localparam int unsigned AW = $clog2(MEM_SIZE);

   logic          i_start;
   logic          i_byte_valid;
   logic [7:0]    i_byte;
   logic          o_byte_ready;
   logic          o_wr_en;
   logic [AW-1:0] o_wr_addr;
   logic [31:0]   o_wr_data;
   logic          o_busy;
   logic          o_done;
   logic          o_err;
   logic          o_cpu_rst;
   logic [31:0]   o_checksum;

   modport slave (
      input  i_start, i_byte_valid, i_byte,
      output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
      output o_busy, o_done, o_err, o_cpu_rst, o_checksum
   );

   modport master (
      output i_start, i_byte_valid, i_byte,
      input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data,
      input  o_busy, o_done, o_err, o_cpu_rst, o_checksum
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Takes a little-endian byte stream made of a 32-bit word count N followed by
// N 32-bit words, and writes the words to instruction memory from word 0 up.
// The CPU is held in reset until a complete, well-formed image has landed.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus_io : slave side of imem_loader_if (stream in, memory write port and
//            status out); all outputs come straight from flops
module imem_loader #(
   parameter int unsigned MEM_SIZE = 1024
) (
   input logic           i_clk,
   input logic           i_rst,
   imem_loader_if.slave  bus_io
);

   localparam int unsigned AW = $clog2(MEM_SIZE);

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StCheck,
      StData,
      StWrite,
      StDone,
      StErr
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [31:0]   len_q, len_d;
   logic [31:0]   word_q, word_d;
   // One extra bit so that N == MEM_SIZE can count to completion without wrapping.
   logic [AW:0]   word_cnt_q, word_cnt_d;
   logic [31:0]   checksum_q, checksum_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          cpu_rst_q, cpu_rst_d;

   logic          accept;
   logic [31:0]   word_shift;
   logic [31:0]   len_shift;

   // ready_q is registered from state_d, so it always matches state_q.
   assign accept     = bus_io.i_byte_valid & ready_q;
   assign word_shift = {bus_io.i_byte, word_q[31:8]};
   assign len_shift  = {bus_io.i_byte, len_q[31:8]};

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      len_d      = len_q;
      word_d     = word_q;
      word_cnt_d = word_cnt_q;
      checksum_d = checksum_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (bus_io.i_start) begin
               state_d    = StHdr;
               byte_cnt_d = 2'd0;
               word_cnt_d = '0;
               checksum_d = 32'd0;
            end
         end
         StHdr: begin
            if (accept) begin
               len_d      = len_shift;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            if (len_q == 32'd0) begin
               state_d = StDone;
            end else if (len_q > 32'(MEM_SIZE)) begin
               state_d = StErr;
            end else begin
               state_d = StData;
            end
         end
         StData: begin
            if (accept) begin
               word_d     = word_shift;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  // Latch the write port now so it is registered in the WRITE cycle.
                  state_d   = StWrite;
                  wr_en_d   = 1'b1;
                  wr_addr_d = word_cnt_q[AW-1:0];
                  wr_data_d = word_shift;
               end
            end
         end
         StWrite: begin
            checksum_d = checksum_q ^ wr_data_q;
            word_cnt_d = word_cnt_q + 1'b1;
            if (32'(word_cnt_q) + 32'd1 == len_q) begin
               state_d = StDone;
            end else begin
               state_d = StData;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      ready_d   = (state_d == StHdr) || (state_d == StData);
      busy_d    = (state_d == StHdr) || (state_d == StCheck) ||
                  (state_d == StData) || (state_d == StWrite);
      done_d    = (state_d == StDone);
      err_d     = (state_d == StErr);
      cpu_rst_d = (state_d != StDone);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         byte_cnt_q <= 2'd0;
         len_q      <= 32'd0;
         word_q     <= 32'd0;
         word_cnt_q <= '0;
         checksum_q <= 32'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 32'd0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cpu_rst_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         len_q      <= len_d;
         word_q     <= word_d;
         word_cnt_q <= word_cnt_d;
         checksum_q <= checksum_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cpu_rst_q  <= cpu_rst_d;
      end
   end

   assign bus_io.o_byte_ready = ready_q;
   assign bus_io.o_wr_en      = wr_en_q;
   assign bus_io.o_wr_addr    = wr_addr_q;
   assign bus_io.o_wr_data    = wr_data_q;
   assign bus_io.o_busy       = busy_q;
   assign bus_io.o_done       = done_q;
   assign bus_io.o_err        = err_q;
   assign bus_io.o_cpu_rst    = cpu_rst_q;
   assign bus_io.o_checksum   = checksum_q;

endmodule
